// File: rtl/cache_ctrl_pkg.sv
// cache_ctrl_pkg
//   Shared definitions for the data-cache sequencer and the cache array:
//   controller state encoding, data-memory base address and the cache
//   address split (tag / index / offset).
package cache_ctrl_pkg;

  localparam int unsigned BASE_ADDR = 1024;

  localparam int unsigned TAG_W    = 10;
  localparam int unsigned INDEX_W  = 6;
  localparam int unsigned OFFSET_W = 3;
  localparam int unsigned CACHE_AW = TAG_W + INDEX_W + OFFSET_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WRITE   = 2'd2
  } state_e;

endpackage

// File: rtl/cache_controller.sv
// cache_controller
//   Sequencer between the MEM stage and the SRAM controller for the 2-way
//   data cache. Read hits are answered from the cache with no stall; read
//   misses fetch a 64-bit block from SRAM, fill it into the cache and return
//   the requested word in the same cycle. Stores write through to SRAM and
//   invalidate any matching cache line (no allocate on store).
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   address, wdata    CPU byte address / store data
//   mem_r_en/mem_w_en CPU load / store request (level, held until ready)
//   rdata, ready      load result / transaction complete (0 stalls pipeline)
//   sram_*            SRAM controller request side; sram_rdata/sram_ready in
//   cache_address     (address - BASE_ADDR) truncated to CACHE_AW bits
//   cache_read_en     lookup + LRU update on a read hit
//   cache_write_en    block fill pulse, cache_fill_data = sram_rdata
//   cache_invoke      invalidate matching line (store)
//   cache_rdata/hit   cache array lookup result
module cache_controller #(
  parameter int unsigned BASE_ADDR = cache_ctrl_pkg::BASE_ADDR,
  parameter int unsigned CACHE_AW  = cache_ctrl_pkg::CACHE_AW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         address,
  input  logic [31:0]         wdata,
  input  logic                mem_r_en,
  input  logic                mem_w_en,
  output logic [31:0]         rdata,
  output logic                ready,
  output logic [31:0]         sram_address,
  output logic [31:0]         sram_wdata,
  output logic                sram_r_en,
  output logic                sram_w_en,
  input  logic [63:0]         sram_rdata,
  input  logic                sram_ready,
  output logic [CACHE_AW-1:0] cache_address,
  output logic                cache_read_en,
  output logic                cache_write_en,
  output logic [63:0]         cache_fill_data,
  output logic                cache_invoke,
  input  logic [31:0]         cache_rdata,
  input  logic                cache_hit
);

  import cache_ctrl_pkg::*;

  state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are combinational from state and the handshake inputs so that
  // hits cost no stall and fills return data in the sram_ready cycle.
  always_comb begin
    state_d         = state_q;
    ready           = 1'b1;
    rdata           = '0;
    sram_address    = '0;
    sram_wdata      = '0;
    sram_r_en       = 1'b0;
    sram_w_en       = 1'b0;
    cache_read_en   = 1'b0;
    cache_write_en  = 1'b0;
    cache_invoke    = 1'b0;
    cache_address   = CACHE_AW'(address - BASE_ADDR);
    cache_fill_data = sram_rdata;

    unique case (state_q)
      IDLE: begin
        // Store has priority when both enables are set.
        if (mem_w_en) begin
          cache_invoke = 1'b1;
          sram_w_en    = 1'b1;
          sram_address = address;
          sram_wdata   = wdata;
          ready        = 1'b0;
          state_d      = WRITE;
        end else if (mem_r_en) begin
          if (cache_hit) begin
            cache_read_en = 1'b1;
            rdata         = cache_rdata;
          end else begin
            sram_r_en    = 1'b1;
            sram_address = address & ~32'h7;
            ready        = 1'b0;
            state_d      = RD_MISS;
          end
        end
      end

      // Does not look at mem_r_en: a dropped request still completes and fills.
      RD_MISS: begin
        sram_r_en    = 1'b1;
        sram_address = address & ~32'h7;
        if (sram_ready) begin
          cache_write_en = 1'b1;
          rdata          = address[2] ? sram_rdata[63:32] : sram_rdata[31:0];
          state_d        = IDLE;
        end else begin
          ready = 1'b0;
        end
      end

      WRITE: begin
        sram_w_en    = 1'b1;
        sram_address = address;
        sram_wdata   = wdata;
        if (sram_ready) begin
          state_d = IDLE;
        end else begin
          ready = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Reset forces the idle output set immediately, independent of the clock.
    if (!rst) begin
      state_d        = IDLE;
      ready          = 1'b1;
      rdata          = '0;
      sram_address   = '0;
      sram_wdata     = '0;
      sram_r_en      = 1'b0;
      sram_w_en      = 1'b0;
      cache_read_en  = 1'b0;
      cache_write_en = 1'b0;
      cache_invoke   = 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller
//   Directed plus randomized bench for cache_controller. Surrounds the DUT
//   with a behavioural SRAM (programmable latency) and a behavioural cache
//   array, and predicts load data, stall counts and strobe activity from a
//   word-level golden memory and a set of blocks expected to be cached.
module tb_cache_controller;

  localparam int unsigned BASE = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address, wdata;
  logic        mem_r_en, mem_w_en;
  logic [31:0] rdata;
  logic        ready;
  logic [31:0] sram_address, sram_wdata;
  logic        sram_r_en, sram_w_en;
  logic [63:0] sram_rdata;
  logic        sram_ready = 1'b0;
  logic [18:0] cache_address;
  logic        cache_read_en, cache_write_en, cache_invoke;
  logic [63:0] cache_fill_data;
  logic [31:0] cache_rdata;
  logic        cache_hit;

  cache_controller #(.BASE_ADDR(BASE), .CACHE_AW(19)) dut (
    .clk(clk), .rst(rst), .address(address), .wdata(wdata),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .rdata(rdata), .ready(ready),
    .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_r_en(sram_r_en), .sram_w_en(sram_w_en), .sram_rdata(sram_rdata),
    .sram_ready(sram_ready), .cache_address(cache_address),
    .cache_read_en(cache_read_en), .cache_write_en(cache_write_en),
    .cache_fill_data(cache_fill_data), .cache_invoke(cache_invoke),
    .cache_rdata(cache_rdata), .cache_hit(cache_hit)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // ---------------- behavioural SRAM ----------------
  logic [63:0] sram_mem [64];
  int unsigned lat = 4;
  int unsigned cnt = 0;

  assign sram_rdata = sram_mem[6'((sram_address - BASE) >> 3)];

  always @(negedge clk) begin : sram_model
    logic [5:0] wi;
    #1;
    if (sram_r_en || sram_w_en) begin
      if (cnt >= lat) begin
        sram_ready = 1'b1;
        cnt = 0;
        if (sram_w_en) begin
          wi = 6'((sram_address - BASE) >> 3);
          if (sram_address[2]) sram_mem[wi][63:32] = sram_wdata;
          else                 sram_mem[wi][31:0]  = sram_wdata;
        end
      end else begin
        sram_ready = 1'b0;
        cnt++;
      end
    end else begin
      sram_ready = 1'b0;
      cnt = 0;
    end
  end

  // ---------------- behavioural cache array ----------------
  logic [63:0] cdata  [64];
  logic        cvalid [64];
  logic [5:0]  cidx;

  assign cidx        = cache_address[8:3];
  assign cache_hit   = cvalid[cidx];
  assign cache_rdata = cache_address[2] ? cdata[cidx][63:32] : cdata[cidx][31:0];

  always @(posedge clk) begin
    if (cache_write_en) begin
      cdata[cidx]  <= cache_fill_data;
      cvalid[cidx] <= 1'b1;
    end
    if (cache_invoke) cvalid[cidx] <= 1'b0;
  end

  // ---------------- reference state ----------------
  logic [31:0] gold [128];
  bit          exp_cached [64];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned exp_stall(input bit hit);
    if (hit) return 0;
    return (lat == 0) ? 1 : lat;
  endfunction

  // Called at a falling edge; returns at the falling edge after completion.
  task automatic do_load(input logic [31:0] a);
    int unsigned stalls = 0, fills = 0, bad = 0, b, w;
    bit done = 0, hit;
    logic [31:0] got = '0;
    logic rd_en = 1'b0;
    b = (a - BASE) >> 3;
    w = (a - BASE) >> 2;
    hit = exp_cached[b];
    address = a; wdata = $urandom; mem_r_en = 1'b1; mem_w_en = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      #2;
      if (c == 0) check("load_cache_address", cache_address, 19'(a - BASE));
      if (cache_write_en) fills++;
      if (sram_w_en || cache_invoke) bad++;
      if (hit && sram_r_en) bad++;
      if (!hit && (!sram_r_en || sram_address !== (a & ~32'h7))) bad++;
      if (ready) begin
        done = 1; got = rdata; rd_en = cache_read_en;
      end else begin
        stalls++;
      end
      @(negedge clk);
    end
    mem_r_en = 1'b0;
    check("load_done", done, 1);
    check("load_stalls", stalls, exp_stall(hit));
    check("load_rdata", got, gold[w]);
    check("load_fills", fills, hit ? 0 : 1);
    check("load_read_en", rd_en, hit);
    check("load_strobes", bad, 0);
    exp_cached[b] = 1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input bit both);
    int unsigned stalls = 0, inv = 0, rreq = 0, fills = 0, bad = 0, wcyc = 0, b, w, es;
    bit done = 0;
    b = (a - BASE) >> 3;
    w = (a - BASE) >> 2;
    es = exp_stall(0);
    address = a; wdata = d; mem_w_en = 1'b1; mem_r_en = both;
    for (int c = 0; c < 64 && !done; c++) begin
      #2;
      if (cache_invoke) inv++;
      if (sram_r_en) rreq++;
      if (cache_write_en || cache_read_en) fills++;
      if (sram_w_en) begin
        wcyc++;
        if (sram_address !== a || sram_wdata !== d) bad++;
      end
      if (ready) done = 1;
      else stalls++;
      @(negedge clk);
    end
    mem_w_en = 1'b0; mem_r_en = 1'b0;
    check("store_done", done, 1);
    check("store_stalls", stalls, es);
    check("store_invoke_pulses", inv, 1);
    check("store_sram_r_en", rreq, 0);
    check("store_cache_activity", fills, 0);
    check("store_w_en_cycles", wcyc, es + 1);
    check("store_addr_data", bad, 0);
    gold[w] = d;
    exp_cached[b] = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    for (int i = 0; i < 64; i++) begin
      sram_mem[i] = {$urandom, $urandom};
      gold[2*i]   = sram_mem[i][31:0];
      gold[2*i+1] = sram_mem[i][63:32];
      cvalid[i]   = 1'b0;
      exp_cached[i] = 0;
    end
    sram_mem[1] = 64'hAAAA_0002_BBBB_0001;
    gold[2] = 32'hBBBB_0001;
    gold[3] = 32'hAAAA_0002;

    // Reset with both requests asserted: outputs must stay in the idle set.
    rst = 1'b0; address = 32'h0000_0408; wdata = 32'h1234_5678;
    mem_r_en = 1'b1; mem_w_en = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check("reset_ready", ready, 1);
    check("reset_rdata", rdata, 0);
    check("reset_strobes", {sram_r_en, sram_w_en, cache_write_en, cache_invoke, cache_read_en}, 0);
    @(negedge clk);
    mem_r_en = 1'b0; mem_w_en = 1'b0; rst = 1'b1;
    @(negedge clk);

    // Miss then back-to-back hit on the same block.
    lat = 4;
    do_load(32'h0000_0408);
    do_load(32'h0000_040C);
    do_load(32'h0000_0408);

    // Store to a cached line, then re-read must miss and see the new data.
    lat = 3;
    do_store(32'h0000_0408, 32'hDEAD_BEEF, 0);
    do_load(32'h0000_0408);

    // Simultaneous enables take the store path.
    lat = 2;
    do_store(32'h0000_0410, 32'hCAFE_F00D, 1);
    do_load(32'h0000_0410);

    // Reset in the second RD_MISS cycle abandons the fill.
    lat = 6;
    a = BASE + 32'd160;
    address = a; mem_r_en = 1'b1;
    @(negedge clk); @(negedge clk);
    #3 rst = 1'b0;
    #1;
    check("midrst_ready", ready, 1);
    check("midrst_rdata", rdata, 0);
    check("midrst_strobes", {sram_r_en, sram_w_en, cache_write_en, cache_invoke}, 0);
    @(negedge clk);
    mem_r_en = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("midrst_no_fill", cvalid[20], 0);
    do_load(a);

    // Zero-latency SRAM.
    lat = 0;
    do_load(BASE + 32'd200);
    do_store(BASE + 32'd204, 32'h0BAD_F00D, 0);
    do_load(BASE + 32'd204);

    // Idle: no request, no strobes.
    for (int i = 0; i < 10; i++) begin
      #2;
      check("idle_ready", ready, 1);
      check("idle_strobes", {sram_r_en, sram_w_en, cache_write_en, cache_invoke, cache_read_en}, 0);
      @(negedge clk);
    end

    // Randomized mix over a small address window to get frequent hits.
    for (int n = 0; n < 60; n++) begin
      lat = $urandom_range(0, 5);
      a = BASE + ($urandom_range(0, 15) << 3) + ($urandom_range(0, 1) << 2);
      case ($urandom_range(0, 3))
        0:       do_store(a, $urandom, 0);
        1:       do_store(a, $urandom, 1);
        default: do_load(a);
      endcase
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
